// File: rtl/servant_pc_tracer.sv
// Compresses the servant fetch-address stream into run-length and full-address trace records,
// buffered in a small FIFO and serialized one byte at a time over a valid/ready port.
`timescale 1ns / 1ps
module servant_pc_tracer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] i_pc_adr,
  input  logic        i_pc_vld,
  input  logic        i_isjump,
  input  logic        i_mret,
  input  logic        i_timer_irq,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_overflow
);

  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Record layout: [43] has_addr, [42:35] count, [34:32] cause, [31:0] addr.
  logic [31:0] last_pc_q, last_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resync_q, resync_d;
  logic        overflow_q, overflow_d;

  logic [43:0]    mem_q [FIFO_DEPTH];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic           fifo_full, fifo_empty;
  logic           push, wr_en, pop;
  logic [43:0]    push_rec, rd_rec;

  logic [43:0] rec_q, rec_d;
  logic [2:0]  pos_q, pos_d;
  logic        tvalid_q, tvalid_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        seq_ev, last_byte;

  // Byte positions: 0 = run marker, 1 = count, 2 = header, 3..6 = address LSB first.
  function automatic logic [7:0] byte_sel(input logic [43:0] rec, input logic [2:0] pos);
    logic [7:0] b;
    case (pos)
      3'd0:    b = 8'h01;
      3'd1:    b = rec[42:35];
      3'd2:    b = {5'b10000, rec[34:32]};
      3'd3:    b = rec[7:0];
      3'd4:    b = rec[15:8];
      3'd5:    b = rec[23:16];
      3'd6:    b = rec[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                      (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign rd_rec     = mem_q[rd_ptr_q[AddrW-1:0]];
  assign seq_ev     = i_pc_vld && !resync_q && (i_pc_adr == last_pc_q + 32'd4);
  assign wr_en      = push && !fifo_full;

  always_comb begin
    last_pc_d  = last_pc_q;
    cnt_d      = cnt_q;
    resync_d   = resync_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_rec   = '0;
    if (i_pc_vld) begin
      last_pc_d = i_pc_adr;
      if (seq_ev && (cnt_q != 8'hff)) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        push = 1'b1;
        if (seq_ev) begin
          push_rec = {1'b0, 8'hff, 3'b000, 32'h0};
          cnt_d    = 8'd1;
        end else begin
          push_rec = {1'b1, cnt_q, i_timer_irq, i_mret, i_isjump, i_pc_adr};
          cnt_d    = 8'd0;
          resync_d = 1'b0;
        end
        // A dropped record forces a full-address resync on the next event.
        if (fifo_full) begin
          overflow_d = 1'b1;
          cnt_d      = 8'd0;
          resync_d   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rec_d     = rec_q;
    pos_d     = pos_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    pop       = 1'b0;
    last_byte = (pos_q == (rec_q[43] ? 3'd6 : 3'd1));
    if (!tvalid_q || (i_tready && last_byte)) begin
      if (!fifo_empty) begin
        pop      = 1'b1;
        rec_d    = rd_rec;
        pos_d    = (rd_rec[42:35] != 8'd0) ? 3'd0 : 3'd2;
        tvalid_d = 1'b1;
        tdata_d  = byte_sel(rd_rec, pos_d);
      end else begin
        tvalid_d = 1'b0;
      end
    end else if (i_tready) begin
      pos_d   = pos_q + 3'd1;
      tdata_d = byte_sel(rec_q, pos_d);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      last_pc_q  <= '0;
      cnt_q      <= '0;
      resync_q   <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rec_q      <= '0;
      pos_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      last_pc_q  <= last_pc_d;
      cnt_q      <= cnt_d;
      resync_q   <= resync_d;
      overflow_q <= overflow_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      rec_q      <= rec_d;
      pos_q      <= pos_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= push_rec;
  end

  assign o_tdata    = tdata_q;
  assign o_tvalid   = tvalid_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_servant_pc_tracer.sv
// Directed bench for servant_pc_tracer: expected trace bytes are queued as fetches are driven
// and checked in order as the DUT transfers them.
`timescale 1ns / 1ps
module tb_servant_pc_tracer;
  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_adr = '0;
  logic        pc_vld = 1'b0;
  logic        isjump = 1'b0;
  logic        mret = 1'b0;
  logic        timer_irq = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        overflow;

  int          tests = 0;
  int          fails = 0;
  int          xfer_cnt = 0;
  logic [7:0]  exp_q[$];
  logic        held = 1'b0;
  logic [7:0]  held_data = '0;

  always #5 clk = ~clk;

  servant_pc_tracer #(.FIFO_DEPTH(Depth)) dut (
    .wb_clk     (clk),
    .wb_rst_n   (rst_n),
    .i_pc_adr   (pc_adr),
    .i_pc_vld   (pc_vld),
    .i_isjump   (isjump),
    .i_mret     (mret),
    .i_timer_irq(timer_irq),
    .o_tdata    (tdata),
    .o_tvalid   (tvalid),
    .i_tready   (tready),
    .o_overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bytes a record should produce on the wire.
  task automatic exp_rec(input logic has, input logic [7:0] cnt, input logic [2:0] cause,
                         input logic [31:0] adr);
    if (cnt != 8'd0) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(cnt);
    end
    if (has) begin
      exp_q.push_back({5'b10000, cause});
      exp_q.push_back(adr[7:0]);
      exp_q.push_back(adr[15:8]);
      exp_q.push_back(adr[23:16]);
      exp_q.push_back(adr[31:24]);
    end
  endtask

  task automatic fetch(input logic [31:0] adr, input logic [2:0] cause);
    pc_adr = adr;
    pc_vld = 1'b1;
    {timer_irq, mret, isjump} = cause;
    @(posedge clk);
    #1;
    pc_vld = 1'b0;
    {timer_irq, mret, isjump} = 3'b000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rnd, input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !tvalid) break;
      if (rnd) tready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    tready = 1'b1;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_idle"}, tvalid, 1'b0);
  endtask

  // Monitor: checks each transferred byte and that a stalled byte holds still.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", tvalid, 1'b1);
        check("hold_data", tdata, held_data);
      end
      if (tvalid && tready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL extra_byte: got %02h expected none", tdata);
        end else begin
          check("byte", tdata, exp_q.pop_front());
        end
      end
      held      = tvalid && !tready;
      held_data = tdata;
    end
  end

  initial begin
    logic [31:0] adr;
    int          base;
    #2;
    do_reset();

    // First fetch after reset, with first-byte latency.
    exp_rec(1'b1, 8'd0, 3'b000, 32'h0);
    fetch(32'h0, 3'b000);
    check("t1_lat0", tvalid, 1'b0);
    @(posedge clk);
    #1;
    check("t1_lat1", tvalid, 1'b1);
    check("t1_first", tdata, 8'h80);
    drain(1'b0, "t1");
    check("t1_overflow", overflow, 1'b0);

    // Sequential run then jump.
    do_reset();
    exp_rec(1'b1, 8'd0, 3'b000, 32'h0);
    exp_rec(1'b1, 8'd3, 3'b001, 32'h100);
    fetch(32'h0, 3'b000);
    fetch(32'h4, 3'b000);
    fetch(32'h8, 3'b000);
    fetch(32'hc, 3'b000);
    fetch(32'h100, 3'b001);
    drain(1'b0, "t2");

    // Counter saturation: 300 sequential fetches split as 255 + 45.
    do_reset();
    exp_rec(1'b1, 8'd0, 3'b000, 32'h0);
    exp_rec(1'b0, 8'd255, 3'b000, 32'h0);
    exp_rec(1'b1, 8'd45, 3'b000, 32'h2000);
    fetch(32'h0, 3'b000);
    for (int i = 1; i <= 300; i++) fetch(32'(i * 4), 3'b000);
    fetch(32'h2000, 3'b000);
    drain(1'b0, "t3");

    // Address wrap counts as sequential; cause bits in header.
    do_reset();
    exp_rec(1'b1, 8'd0, 3'b000, 32'hffff_fffc);
    exp_rec(1'b1, 8'd1, 3'b110, 32'h10);
    fetch(32'hffff_fffc, 3'b000);
    fetch(32'h0, 3'b000);
    fetch(32'h10, 3'b110);
    drain(1'b0, "t4");

    // Overflow: the serializer holds one record and the FIFO Depth more, so the
    // (Depth+2)th back-to-back discontinuity is the first one dropped.
    do_reset();
    tready = 1'b0;
    adr    = '0;
    for (int k = 0; k < int'(Depth) + 2; k++) begin
      adr = {8'(k + 1), 8'ha5, 8'(k * 3), 8'h40};
      if (k <= int'(Depth)) exp_rec(1'b1, 8'd0, 3'(k), adr);
      if (k == int'(Depth) + 1) check("t5_no_overflow_yet", overflow, 1'b0);
      fetch(adr, 3'(k));
    end
    check("t5_overflow", overflow, 1'b1);
    drain(1'b1, "t5");
    exp_rec(1'b1, 8'd0, 3'b000, adr + 32'd4);
    fetch(adr + 32'd4, 3'b000);
    drain(1'b1, "t5_resync");
    check("t5_sticky", overflow, 1'b1);

    // Reset in the middle of a packet.
    do_reset();
    exp_rec(1'b1, 8'd0, 3'b000, 32'hdead_bee0);
    base = xfer_cnt;
    fetch(32'hdead_bee0, 3'b000);
    for (int i = 0; i < 20 && xfer_cnt < base + 2; i++) @(posedge clk);
    #1;
    check("t6_two_bytes", xfer_cnt - base, 2);
    check("t6_mid_valid", tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", tvalid, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_rec(1'b1, 8'd0, 3'b000, 32'hdead_bee4);
    fetch(32'hdead_bee4, 3'b000);
    drain(1'b0, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
